// File: rtl/d_sync_down_counter.sv
// Synchronous loadable down counter with complementary outputs, terminal count,
// underflow pulse and one-shot done flag. Optional Gray output: D_SYNC_DOWN_CNT_GRAY_EN.
module d_sync_down_counter #(
    parameter int               WIDTH      = 4,
    parameter logic [WIDTH-1:0] RESET_VAL  = {WIDTH{1'b1}},
    parameter logic [WIDTH-1:0] RELOAD_VAL = {WIDTH{1'b1}}
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             one_shot,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] qbar,
    output logic             tc,
    output logic             underflow,
    output logic             done
`ifdef D_SYNC_DOWN_CNT_GRAY_EN
    ,
    output logic [WIDTH-1:0] q_gray
`endif
);

    localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

    function automatic logic [WIDTH-1:0] to_gray(input logic [WIDTH-1:0] v);
        return v ^ (v >> 1);
    endfunction

    logic [WIDTH-1:0] q_nxt;
    logic             done_nxt;
    logic             uf_nxt;

    // Next state from current state; reset is applied in the register process.
    always_comb begin
        q_nxt    = q;
        done_nxt = done;
        uf_nxt   = 1'b0;
        if (load) begin
            q_nxt    = load_val;
            done_nxt = 1'b0;
        end else if (en) begin
            if (q != '0) begin
                q_nxt = q - ONE;
            end else if (!one_shot) begin
                q_nxt  = RELOAD_VAL;
                uf_nxt = 1'b1;
            end else begin
                done_nxt = 1'b1;
            end
        end
    end

    // q, qbar (and q_gray) all load from the same next-state value so they never skew.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            q         <= RESET_VAL;
            qbar      <= ~RESET_VAL;
            underflow <= 1'b0;
            done      <= 1'b0;
        end else begin
            q         <= q_nxt;
            qbar      <= ~q_nxt;
            underflow <= uf_nxt;
            done      <= done_nxt;
        end
    end

`ifdef D_SYNC_DOWN_CNT_GRAY_EN
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            q_gray <= to_gray(RESET_VAL);
        end else begin
            q_gray <= to_gray(q_nxt);
        end
    end
`endif

    assign tc = (q == '0);

endmodule

// File: tb/tb_d_sync_down_counter.sv
// Table-driven scoreboard bench for d_sync_down_counter at default width.
module tb_d_sync_down_counter;

    logic       clk = 1'b0;
    logic       rst_n, en, load, one_shot;
    logic [3:0] load_val;
    logic [3:0] q, qbar;
    logic       tc, underflow, done;
`ifdef D_SYNC_DOWN_CNT_GRAY_EN
    logic [3:0] q_gray;
`endif

    d_sync_down_counter dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (en),
        .load      (load),
        .load_val  (load_val),
        .one_shot  (one_shot),
        .q         (q),
        .qbar      (qbar),
        .tc        (tc),
        .underflow (underflow),
        .done      (done)
`ifdef D_SYNC_DOWN_CNT_GRAY_EN
        ,
        .q_gray    (q_gray)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       rst_n;
        logic       load;
        logic [3:0] load_val;
        logic       en;
        logic       one_shot;
        logic [3:0] exp_q;
        logic       exp_uf;
        logic       exp_done;
        string      name;
    } vec_t;

    typedef struct {
        logic [3:0] q;
        logic       uf;
        logic       done;
        string      name;
    } exp_t;

    vec_t vecs[$];
    exp_t sb[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    function automatic void add(input logic r, input logic ld, input logic [3:0] lv,
                                input logic e, input logic os, input logic [3:0] eq,
                                input logic eu, input logic ed, input string nm);
        vec_t v;
        v.rst_n = r; v.load = ld; v.load_val = lv; v.en = e; v.one_shot = os;
        v.exp_q = eq; v.exp_uf = eu; v.exp_done = ed; v.name = nm;
        vecs.push_back(v);
    endfunction

    task automatic cmp(input string nm, input logic [15:0] act, input logic [15:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, req);
        end
    endtask

    // Drive one vector before the edge, push its expectation, then pop and compare after the edge.
    task automatic apply(input vec_t v);
        exp_t e;
        @(negedge clk);
        rst_n = v.rst_n; load = v.load; load_val = v.load_val;
        en = v.en; one_shot = v.one_shot;
        e.q = v.exp_q; e.uf = v.exp_uf; e.done = v.exp_done; e.name = v.name;
        sb.push_back(e);
        @(posedge clk);
        #1;
        if (sb.size() == 0) begin
            cmp({"scoreboard_empty_", v.name}, 16'd1, 16'd0);
        end else begin
            e = sb.pop_front();
            cmp({e.name, ".q"}, {12'd0, q}, {12'd0, e.q});
            cmp({e.name, ".qbar"}, {12'd0, qbar}, {12'd0, ~e.q});
            cmp({e.name, ".tc"}, {15'd0, tc}, {15'd0, (e.q == 4'h0)});
            cmp({e.name, ".underflow"}, {15'd0, underflow}, {15'd0, e.uf});
            cmp({e.name, ".done"}, {15'd0, done}, {15'd0, e.done});
`ifdef D_SYNC_DOWN_CNT_GRAY_EN
            cmp({e.name, ".q_gray"}, {12'd0, q_gray}, {12'd0, e.q ^ (e.q >> 1)});
`endif
        end
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time budget");
        $fatal(1, "timeout");
    end

    initial begin
        vec_t hv;
        rst_n = 1'b0; en = 1'b0; load = 1'b0; load_val = 4'h0; one_shot = 1'b0;

        // Reset with load and en both high.
        add(0, 1, 4'h3, 1, 0, 4'hF, 0, 0, "reset0");
        add(0, 1, 4'h3, 1, 0, 4'hF, 0, 0, "reset1");
        // Free-run: F -> 0, wrap to F with underflow, then E.
        for (int i = 1; i <= 15; i++) add(1, 0, 4'h0, 1, 0, 4'(15 - i), 0, 0, "freerun");
        add(1, 0, 4'h0, 1, 0, 4'hF, 1, 0, "wrap");
        add(1, 0, 4'h0, 1, 0, 4'hE, 0, 0, "after_wrap");
        // One-shot from 3.
        add(1, 1, 4'h3, 1, 1, 4'h3, 0, 0, "os_load");
        add(1, 0, 4'h0, 1, 1, 4'h2, 0, 0, "os_2");
        add(1, 0, 4'h0, 1, 1, 4'h1, 0, 0, "os_1");
        add(1, 0, 4'h0, 1, 1, 4'h0, 0, 0, "os_0");
        add(1, 0, 4'h0, 1, 1, 4'h0, 0, 1, "os_done");
        add(1, 0, 4'h0, 1, 1, 4'h0, 0, 1, "os_sticky");
        add(1, 0, 4'h0, 0, 1, 4'h0, 0, 1, "os_en_low");
        add(1, 0, 4'h0, 1, 1, 4'h0, 0, 1, "os_en_high");
        // Leaving one-shot while done: wrap, done stays set.
        add(1, 0, 4'h0, 1, 0, 4'hF, 1, 1, "os_exit_wrap");
        add(1, 0, 4'h0, 0, 0, 4'hF, 0, 1, "os_exit_hold");
        // Load beats enable.
        add(1, 1, 4'h5, 0, 0, 4'h5, 0, 0, "prio_load5");
        add(1, 1, 4'hA, 1, 0, 4'hA, 0, 0, "prio_loadA");
        add(1, 0, 4'h0, 1, 0, 4'h9, 0, 0, "prio_dec");
        // Enable gating.
        add(1, 1, 4'h7, 0, 0, 4'h7, 0, 0, "gate_load7");
        add(1, 0, 4'h0, 1, 0, 4'h6, 0, 0, "gate_en1");
        add(1, 0, 4'h0, 0, 0, 4'h6, 0, 0, "gate_en0a");
        add(1, 0, 4'h0, 0, 0, 4'h6, 0, 0, "gate_en0b");
        add(1, 0, 4'h0, 1, 0, 4'h5, 0, 0, "gate_en1b");
        // load_val = 0: done waits for the next enabled edge.
        add(1, 1, 4'h0, 1, 1, 4'h0, 0, 0, "load_zero");
        add(1, 0, 4'h0, 1, 1, 4'h0, 0, 1, "load_zero_done");

        foreach (vecs[i]) apply(vecs[i]);

        // Hand sequence: reach q = 4 with done = 1, then reset mid-count with load high.
        hv = '{rst_n: 1, load: 0, load_val: 4'h0, en: 1, one_shot: 0,
               exp_q: 4'hF, exp_uf: 1, exp_done: 1, name: "mid_wrap"};
        apply(hv);
        for (int k = 14; k >= 4; k--) begin
            hv.exp_q = 4'(k); hv.exp_uf = 0; hv.name = "mid_count";
            apply(hv);
        end
        hv = '{rst_n: 0, load: 1, load_val: 4'h2, en: 1, one_shot: 0,
               exp_q: 4'hF, exp_uf: 0, exp_done: 0, name: "mid_reset"};
        apply(hv);
        hv = '{rst_n: 1, load: 0, load_val: 4'h0, en: 0, one_shot: 0,
               exp_q: 4'hF, exp_uf: 0, exp_done: 0, name: "post_reset_hold"};
        apply(hv);

        cmp("scoreboard_drained", 16'(sb.size()), 16'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
